// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, register-file sizing, the R15
// side-result index, common typedefs and the ALU ctrl opcode constants.
package cpu_pkg;

  localparam int DATA_W  = 16;  // register / operand width
  localparam int ADDR_W  = 4;   // register address width
  localparam int NREGS   = 16;  // number of registers, equals 2**ADDR_W
  localparam int R15_IDX = 15;  // register receiving the ALU R15 output

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [NREGS-1:0]  reg_mask_t;

  // ALU ctrl opcodes (ALU ctrl input encoding)
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SHL = 4'h5;
  localparam logic [3:0] ALU_SHR = 4'h6;
  localparam logic [3:0] ALU_MUL = 4'h7;  // high word goes to R15
  localparam logic [3:0] ALU_DIV = 4'h8;  // remainder goes to R15

  // Register-address compare against the R15 side-result register.
  function automatic logic is_r15(input reg_addr_t addr);
    return addr == reg_addr_t'(R15_IDX);
  endfunction

endpackage

// File: rtl/alu_operand_regfile_scoreboard.sv
// Per-register busy scoreboard for RAW-hazard stalls.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   iss_en/iss_addr/iss_r15  issue strobe, destination, "also writes R15"
//   wr_en/wr_addr            general write commit (clears busy)
//   r15_wr_en                R15 side-result commit (clears busy[R15])
//   rd_addr_a/rd_addr_b      read addresses checked for hazards
//   wr_hit_a/wr_hit_b        an active write this cycle targets that read address
//   busy_vec                 bit i = register i has a pending write
//   hazard                   a read targets a busy register not being written now
module alu_operand_regfile_scoreboard
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      iss_en,
  input  reg_addr_t iss_addr,
  input  logic      iss_r15,
  input  logic      wr_en,
  input  reg_addr_t wr_addr,
  input  logic      r15_wr_en,
  input  reg_addr_t rd_addr_a,
  input  reg_addr_t rd_addr_b,
  input  logic      wr_hit_a,
  input  logic      wr_hit_b,
  output reg_mask_t busy_vec,
  output logic      hazard
);

  reg_mask_t r_busy;
  reg_mask_t w_set;
  reg_mask_t w_clr;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (iss_en)             w_set[iss_addr] = 1'b1;
    if (iss_en && iss_r15)  w_set[R15_IDX]  = 1'b1;
    if (wr_en)              w_clr[wr_addr]  = 1'b1;
    if (r15_wr_en)          w_clr[R15_IDX]  = 1'b1;
  end

  // Set is applied after clear so a new producer issued in the same cycle
  // that the old one retires keeps the register busy.
  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= (r_busy & ~w_clr) | w_set;
  end

  assign busy_vec = r_busy;
  // Uses the registered busy state only, so an issue this cycle is seen next cycle.
  assign hazard = (r_busy[rd_addr_a] & ~wr_hit_a) | (r_busy[rd_addr_b] & ~wr_hit_b);

endmodule

// File: rtl/alu_operand_regfile.sv
// Operand register file for the 16-bit ALU: 16 x 16-bit registers, two
// combinational read ports with same-cycle write bypass, a general write
// port for ALU res, a dedicated R15 port for the side result, and a busy
// scoreboard for RAW-hazard stalls.
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   rd_addr_a/b, rd_data_a/b    read ports feeding ALU a / b
//   wr_en, wr_addr, wr_data     general write (ALU res)
//   r15_wr_en, r15_data         R15 side-result write
//   iss_en, iss_addr, iss_r15   issue strobe marking destinations busy
//   busy_vec, hazard            scoreboard state and read hazard flag
module alu_operand_regfile
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  reg_addr_t rd_addr_a,
  input  reg_addr_t rd_addr_b,
  output word_t     rd_data_a,
  output word_t     rd_data_b,
  input  logic      wr_en,
  input  reg_addr_t wr_addr,
  input  word_t     wr_data,
  input  logic      r15_wr_en,
  input  word_t     r15_data,
  input  logic      iss_en,
  input  reg_addr_t iss_addr,
  input  logic      iss_r15,
  output reg_mask_t busy_vec,
  output logic      hazard
);

  // NREGS == 2**ADDR_W, so every address selects a real register.
  word_t r_regs [NREGS];

  logic w_wr_hit_a;
  logic w_wr_hit_b;

  // Bypass priority matches storage priority: R15 port beats the general port.
  function automatic word_t read_port(input reg_addr_t addr);
    if (r15_wr_en && is_r15(addr))   return r15_data;
    if (wr_en && (wr_addr == addr))  return wr_data;
    return r_regs[addr];
  endfunction

  always_comb begin
    rd_data_a  = read_port(rd_addr_a);
    rd_data_b  = read_port(rd_addr_b);
    w_wr_hit_a = (wr_en && (wr_addr == rd_addr_a)) || (r15_wr_en && is_r15(rd_addr_a));
    w_wr_hit_b = (wr_en && (wr_addr == rd_addr_b)) || (r15_wr_en && is_r15(rd_addr_b));
  end

  // The R15 assignment comes last so it overrides a general write to R15.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      if (wr_en)     r_regs[wr_addr] <= wr_data;
      if (r15_wr_en) r_regs[R15_IDX] <= r15_data;
    end
  end

  alu_operand_regfile_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .iss_r15   (iss_r15),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .r15_wr_en (r15_wr_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .wr_hit_a  (w_wr_hit_a),
    .wr_hit_b  (w_wr_hit_b),
    .busy_vec  (busy_vec),
    .hazard    (hazard)
  );

endmodule

// File: tb/tb_alu_operand_regfile.sv
module tb_alu_operand_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rd_addr_a, rd_addr_b, wr_addr, iss_addr;
  logic [15:0] rd_data_a, rd_data_b, wr_data, r15_data;
  logic        wr_en, r15_wr_en, iss_en, iss_r15;
  logic [15:0] busy_vec;
  logic        hazard;

  int checks = 0;
  int errors = 0;

  // reference state: register contents and outstanding-producer flags
  logic [15:0] m_regs [16];
  bit          m_busy [16];
  logic [15:0] exp_q [$];

  alu_operand_regfile dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .r15_wr_en(r15_wr_en), .r15_data(r15_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_r15(iss_r15),
    .busy_vec(busy_vec), .hazard(hazard)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // writes landing at the next edge; the R15 port overrides a general write to 15
  function automatic void pending(output logic [15:0] val [16], output bit hit [16]);
    for (int i = 0; i < 16; i++) begin val[i] = '0; hit[i] = 0; end
    if (wr_en)     begin val[wr_addr] = wr_data; hit[wr_addr] = 1; end
    if (r15_wr_en) begin val[15] = r15_data;     hit[15] = 1; end
  endfunction

  task automatic predict();
    logic [15:0] val [16];
    bit          hit [16];
    logic [15:0] bv;
    pending(val, hit);
    bv = '0;
    for (int i = 0; i < 16; i++) bv[i] = m_busy[i];
    exp_q.push_back(hit[rd_addr_a] ? val[rd_addr_a] : m_regs[rd_addr_a]);
    exp_q.push_back(hit[rd_addr_b] ? val[rd_addr_b] : m_regs[rd_addr_b]);
    exp_q.push_back(bv);
    exp_q.push_back({15'd0, (m_busy[rd_addr_a] && !hit[rd_addr_a]) ||
                            (m_busy[rd_addr_b] && !hit[rd_addr_b])});
  endtask

  task automatic commit();
    logic [15:0] val [16];
    bit          hit [16];
    pending(val, hit);
    if (rst) begin
      for (int i = 0; i < 16; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
    end else begin
      for (int i = 0; i < 16; i++) if (hit[i]) begin m_regs[i] = val[i]; m_busy[i] = 0; end
      if (iss_en) m_busy[iss_addr] = 1;
      if (iss_en && iss_r15) m_busy[15] = 1;
    end
  endtask

  // driver tasks
  task automatic idle();
    rst = 0; wr_en = 0; wr_addr = 0; wr_data = 0; r15_wr_en = 0; r15_data = 0;
    iss_en = 0; iss_addr = 0; iss_r15 = 0; rd_addr_a = 0; rd_addr_b = 0;
  endtask

  // inputs already driven; check combinational outputs, then clock them in
  task automatic run_cycle(input string tag, input bit do_check);
    #3;
    if (do_check) begin
      predict();
      check({tag, "_rda"}, rd_data_a, exp_q.pop_front());
      check({tag, "_rdb"}, rd_data_b, exp_q.pop_front());
      check({tag, "_busy"}, busy_vec, exp_q.pop_front());
      check({tag, "_haz"}, {15'd0, hazard}, exp_q.pop_front());
    end
    @(posedge clk);
    commit();
    #1;
    idle();
  endtask

  function automatic logic [3:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) begin m_regs[i] = 'x; m_busy[i] = 0; end
    idle();

    // 1 reset beats a simultaneous write
    rst = 1; wr_en = 1; wr_addr = 3; wr_data = 16'hFFFF;
    run_cycle("rst", 0);
    rd_addr_a = 3;
    #3;
    check("t1_r3", rd_data_a, 16'h0000);
    check("t1_busy", busy_vec, 16'h0000);
    check("t1_haz", {15'd0, hazard}, 16'h0000);
    run_cycle("t1", 1);

    // 2 write then read
    wr_en = 1; wr_addr = 2; wr_data = 16'h0004; run_cycle("t2w2", 1);
    wr_en = 1; wr_addr = 5; wr_data = 16'h0002; run_cycle("t2w5", 1);
    rd_addr_a = 2; rd_addr_b = 5;
    #3;
    check("t2_rda", rd_data_a, 16'h0004);
    check("t2_rdb", rd_data_b, 16'h0002);
    run_cycle("t2", 1);

    // 3 same-cycle bypass
    wr_en = 1; wr_addr = 7; wr_data = 16'h1234; rd_addr_a = 7;
    #3;
    check("t3_bypass", rd_data_a, 16'h1234);
    run_cycle("t3", 1);

    // 4 R15 port wins over general write to 15
    wr_en = 1; wr_addr = 15; wr_data = 16'hAAAA; r15_wr_en = 1; r15_data = 16'h0001;
    rd_addr_b = 15;
    #3;
    check("t4_bypass", rd_data_b, 16'h0001);
    run_cycle("t4w", 1);
    rd_addr_a = 15;
    #3;
    check("t4_r15", rd_data_a, 16'h0001);
    run_cycle("t4", 1);

    // 5 issue, hazard, retire
    iss_en = 1; iss_addr = 4; iss_r15 = 1; rd_addr_a = 4;
    #3;
    check("t5_haz_same", {15'd0, hazard}, 16'h0000);
    run_cycle("t5i", 1);
    rd_addr_a = 4;
    #3;
    check("t5_busy", busy_vec, 16'h8010);
    check("t5_haz", {15'd0, hazard}, 16'h0001);
    run_cycle("t5h", 1);
    rd_addr_a = 4; wr_en = 1; wr_addr = 4; wr_data = 16'h0099;
    #3;
    check("t5_haz_wr", {15'd0, hazard}, 16'h0000);
    run_cycle("t5c4", 1);
    check("t5_busy4", busy_vec, 16'h8000);
    r15_wr_en = 1; r15_data = 16'h0777; run_cycle("t5c15", 1);
    check("t5_busy15", busy_vec, 16'h0000);

    // 6 set/clear collision
    iss_en = 1; iss_addr = 6; run_cycle("t6i", 1);
    iss_en = 1; iss_addr = 6; wr_en = 1; wr_addr = 6; wr_data = 16'h0042; run_cycle("t6c", 1);
    rd_addr_a = 6;
    #3;
    check("t6_r6", rd_data_a, 16'h0042);
    check("t6_busy", busy_vec, 16'h0040);
    run_cycle("t6", 1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 60) == 0);
      rd_addr_a = rnd_addr();
      rd_addr_b = rnd_addr();
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_addr   = rnd_addr();
      wr_data   = 16'($urandom());
      r15_wr_en = ($urandom_range(0, 3) == 0);
      r15_data  = 16'($urandom());
      iss_en    = ($urandom_range(0, 1) == 1);
      iss_addr  = rnd_addr();
      iss_r15   = ($urandom_range(0, 3) == 0);
      run_cycle("rand", 1);
    end

    if (exp_q.size() != 0) check("exp_q_drain", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
